// File: rtl/alu_seq_pkg.sv
// Shared encodings for the sequential ALU: op codes, FSM states and flag bit positions.
package alu_seq_pkg;

  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_INC = 5'd3;
  localparam logic [4:0] OP_DEC = 5'd4;
  localparam logic [4:0] OP_MOD = 5'd5;
  localparam logic [4:0] OP_AND = 5'd6;
  localparam logic [4:0] OP_CMP = 5'd7;
  localparam logic [4:0] OP_MOV = 5'd8;
  localparam logic [4:0] OP_NOT = 5'd9;
  localparam logic [4:0] OP_OR  = 5'd10;
  localparam logic [4:0] OP_XOR = 5'd11;
  localparam logic [4:0] OP_MUL = 5'd12;
  localparam logic [4:0] OP_LSL = 5'd13;
  localparam logic [4:0] OP_LSR = 5'd14;
  localparam logic [4:0] OP_RSL = 5'd15;
  localparam logic [4:0] OP_RSR = 5'd16;
  localparam logic [4:0] OP_DIV = 5'd17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    MUL_IT = 2'd2,
    DIV_IT = 2'd3
  } state_t;

  localparam int F_Z  = 0;
  localparam int F_N  = 1;
  localparam int F_C  = 2;
  localparam int F_V  = 3;
  localparam int F_DZ = 4;

  function automatic logic op_is_legal(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_DIV);
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative shift-add multiplier / restoring divider shared by MUL, DIV and MOD.
module alu_seq_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] dsr;
  logic             mode_q;
  logic [CW-1:0]    cnt;
  logic             busy;

  logic [WIDTH-1:0] hi_in, lo_in, b_in, hi_nx, lo_nx;
  logic             mode_in;
  logic [WIDTH:0]   sum, trial, diff;

  assign done = busy && (cnt == '0);

  // One iteration step; the first step runs on the accept edge from the raw operands,
  // so WIDTH steps finish one edge before the core latches the result.
  always_comb begin
    hi_in   = start ? '0 : hi;
    lo_in   = start ? a : lo;
    b_in    = start ? b : dsr;
    mode_in = start ? mode : mode_q;
    sum     = '0;
    trial   = '0;
    diff    = '0;
    hi_nx   = hi_in;
    lo_nx   = lo_in;
    if (!mode_in) begin
      sum            = {1'b0, hi_in} + (lo_in[0] ? {1'b0, b_in} : '0);
      {hi_nx, lo_nx} = {sum, lo_in[WIDTH-1:1]};
    end else begin
      trial = {hi_in, lo_in[WIDTH-1]};
      diff  = trial - {1'b0, b_in};
      if (!diff[WIDTH]) begin
        hi_nx = diff[WIDTH-1:0];
        lo_nx = {lo_in[WIDTH-2:0], 1'b1};
      end else begin
        hi_nx = trial[WIDTH-1:0];
        lo_nx = {lo_in[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Working registers and down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      dsr    <= '0;
      mode_q <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      hi     <= hi_nx;
      lo     <= lo_nx;
      dsr    <= b;
      mode_q <= mode;
      cnt    <= CW'(WIDTH - 1);
      busy   <= 1'b1;
    end else if (busy) begin
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        hi  <= hi_nx;
        lo  <= lo_nx;
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked sequential ALU: single-cycle datapath, control FSM and status flags.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [4:0]       op_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             res_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] aux,
  output logic [4:0]       flags,
  output logic             err
);

  state_t state, state_nx;

  logic [4:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               cin_q;
  logic               accept, is_div, start, it_done;
  logic [WIDTH-1:0]   it_hi, it_lo, it_res;
  logic [4:0]         it_flags, ex_flags;
  logic [WIDTH-1:0]   val, ex_aux;
  logic               wr_res, wr_aux, c, v, dz;
  logic [WIDTH:0]     wide;
  logic [2*WIDTH-1:0] rot;

  assign op_ready = (state == IDLE);
  assign accept   = op_valid && op_ready;
  assign is_div   = (op_code == OP_DIV) || (op_code == OP_MOD);
  assign start    = accept && ((op_code == OP_MUL) || (is_div && (b != '0)));

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (is_div),
    .a     (a),
    .b     (b),
    .done  (it_done),
    .hi    (it_hi),
    .lo    (it_lo)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state selection; divide by zero takes the single-cycle path.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (op_code == OP_MUL)             state_nx = MUL_IT;
          else if (is_div && (b != '0))      state_nx = DIV_IT;
          else                               state_nx = EXEC;
        end
      end
      EXEC:           state_nx = IDLE;
      MUL_IT, DIV_IT: if (it_done) state_nx = IDLE;
      default:        state_nx = IDLE;
    endcase
  end

  // Single-cycle datapath on the latched operands.
  always_comb begin
    val    = result;
    ex_aux = aux;
    wr_res = 1'b1;
    wr_aux = 1'b0;
    c      = 1'b0;
    v      = 1'b0;
    dz     = 1'b0;
    wide   = '0;
    rot    = '0;
    case (op_q)
      OP_ADD: begin
        wide = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
        val  = wide[WIDTH-1:0];
        c    = wide[WIDTH];
        v    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (val[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_INC: begin
        wide = {1'b0, a_q} + {{WIDTH{1'b0}}, 1'b1};
        val  = wide[WIDTH-1:0];
        c    = wide[WIDTH];
        v    = !a_q[WIDTH-1] && val[WIDTH-1];
      end
      OP_SUB, OP_CMP: begin
        wide   = {1'b0, a_q} - {1'b0, b_q}
               - {{WIDTH{1'b0}}, (op_q == OP_SUB) ? cin_q : 1'b0};
        val    = wide[WIDTH-1:0];
        c      = wide[WIDTH];
        v      = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (val[WIDTH-1] != a_q[WIDTH-1]);
        wr_res = (op_q == OP_SUB);
      end
      OP_DEC: begin
        wide = {1'b0, a_q} - {{WIDTH{1'b0}}, 1'b1};
        val  = wide[WIDTH-1:0];
        c    = wide[WIDTH];
        v    = a_q[WIDTH-1] && !val[WIDTH-1];
      end
      OP_AND: val = a_q & b_q;
      OP_OR:  val = a_q | b_q;
      OP_XOR: val = a_q ^ b_q;
      OP_NOT: val = ~a_q;
      OP_MOV: val = a_q;
      OP_LSL: begin
        wide = {1'b0, a_q} << b_q;
        val  = wide[WIDTH-1:0];
        c    = wide[WIDTH];
      end
      OP_LSR: begin
        wide = {a_q, 1'b0} >> b_q;
        val  = wide[WIDTH:1];
        c    = wide[0];
      end
      OP_RSL: begin
        rot = {a_q, a_q} << b_q[SHW-1:0];
        val = rot[2*WIDTH-1:WIDTH];
      end
      OP_RSR: begin
        rot = {a_q, a_q} >> b_q[SHW-1:0];
        val = rot[WIDTH-1:0];
      end
      OP_DIV, OP_MOD: begin
        val    = '1;
        ex_aux = a_q;
        wr_aux = 1'b1;
        dz     = 1'b1;
      end
      default: wr_res = 1'b0;
    endcase
    ex_flags       = '0;
    ex_flags[F_Z]  = (val == '0);
    ex_flags[F_N]  = val[WIDTH-1];
    ex_flags[F_C]  = c;
    ex_flags[F_V]  = v;
    ex_flags[F_DZ] = dz;
  end

  // Result selection and flags for the iterative ops.
  always_comb begin
    it_res        = (op_q == OP_MOD) ? it_hi : it_lo;
    it_flags      = '0;
    it_flags[F_Z] = (it_res == '0);
    it_flags[F_N] = it_res[WIDTH-1];
  end

  // Operand latch and architectural outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      result    <= '0;
      aux       <= '0;
      flags     <= '0;
      res_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      err       <= 1'b0;
      if (accept) begin
        op_q  <= op_code;
        a_q   <= a;
        b_q   <= b;
        cin_q <= cin;
      end
      if (state == EXEC) begin
        res_valid <= 1'b1;
        if (!op_is_legal(op_q)) begin
          err <= 1'b1;
        end else begin
          flags <= ex_flags;
          if (wr_res) result <= val;
          if (wr_aux) aux    <= ex_aux;
        end
      end else if (((state == MUL_IT) || (state == DIV_IT)) && it_done) begin
        res_valid <= 1'b1;
        result    <= it_res;
        aux       <= it_hi;
        flags     <= it_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core: vector table plus hand-written multi-cycle sequences.
module tb_alu_seq_core;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_ready, cin, res_valid, err;
  logic [4:0]  op_code, flags;
  logic [15:0] a, b, result, aux;

  logic        op_valid8, op_ready8, cin8, res_valid8, err8;
  logic [4:0]  op_code8, flags8;
  logic [7:0]  a8, b8, result8, aux8;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_seq_core #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .a(a), .b(b), .cin(cin), .res_valid(res_valid),
    .result(result), .aux(aux), .flags(flags), .err(err)
  );

  alu_seq_core #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .op_valid(op_valid8), .op_ready(op_ready8),
    .op_code(op_code8), .a(a8), .b(b8), .cin(cin8), .res_valid(res_valid8),
    .result(result8), .aux(aux8), .flags(flags8), .err(err8)
  );

  typedef struct {
    logic [4:0]  op;
    logic [15:0] va;
    logic [15:0] vb;
    logic        vcin;
    logic [15:0] res;
    logic [15:0] ax;
    logic [4:0]  fl;
    logic        er;
    int          lat;
  } vec_t;

  vec_t vt [28];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Presents one op and counts cycles (accept cycle = 1) until res_valid; -1 on timeout.
  task automatic run_op(input logic [4:0] op, input logic [15:0] ia, input logic [15:0] ib,
                        input logic icin, input bit hold, input logic [4:0] aop,
                        input logic [15:0] aa, input logic [15:0] ab,
                        output int lat, output bit busy_ok);
    op_code  = op;
    a        = ia;
    b        = ib;
    cin      = icin;
    op_valid = 1'b1;
    lat      = -1;
    busy_ok  = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        if (hold) begin
          op_code = aop;
          a       = aa;
          b       = ab;
          cin     = 1'b0;
        end else begin
          op_valid = 1'b0;
        end
      end
      if (res_valid) begin
        lat = n;
        if (!op_ready) busy_ok = 1'b0;
        break;
      end
      if (op_ready) busy_ok = 1'b0;
    end
  endtask

  task automatic exec_check(input string name, input vec_t t);
    int lat;
    bit bok;
    run_op(t.op, t.va, t.vb, t.vcin, 1'b0, 5'd0, 16'h0, 16'h0, lat, bok);
    check({name, "_lat"},   32'(lat), 32'(t.lat));
    check({name, "_res"},   {16'h0, result}, {16'h0, t.res});
    check({name, "_aux"},   {16'h0, aux}, {16'h0, t.ax});
    check({name, "_flags"}, {27'h0, flags}, {27'h0, t.fl});
    check({name, "_err"},   {31'h0, err}, {31'h0, t.er});
    check({name, "_ready"}, {31'h0, bok}, 32'h1);
  endtask

  task automatic run8(input string name, input logic [4:0] op, input logic [7:0] ia,
                      input logic [7:0] ib, input logic [7:0] eres, input logic [7:0] eaux,
                      input logic [4:0] efl, input int elat);
    int lat;
    op_code8  = op;
    a8        = ia;
    b8        = ib;
    cin8      = 1'b0;
    op_valid8 = 1'b1;
    lat       = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      op_valid8 = 1'b0;
      if (res_valid8) begin
        lat = n;
        break;
      end
    end
    check({name, "_lat"},   32'(lat), 32'(elat));
    check({name, "_res"},   {24'h0, result8}, {24'h0, eres});
    check({name, "_aux"},   {24'h0, aux8}, {24'h0, eaux});
    check({name, "_flags"}, {27'h0, flags8}, {27'h0, efl});
    check({name, "_err"},   {31'h0, err8}, 32'h0);
  endtask

  initial begin
    int  lat;
    bit  bok;
    bit  seen;

    //          op      a         b         cin   result    aux       {DZ,V,C,N,Z} err lat
    vt[0]  = '{OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h0000, 5'b01010, 1'b0, 2};
    vt[1]  = '{OP_SUB, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 16'h0000, 5'b00110, 1'b0, 2};
    vt[2]  = '{OP_CMP, 16'h0009, 16'h0009, 1'b0, 16'hFFFE, 16'h0000, 5'b00001, 1'b0, 2};
    vt[3]  = '{OP_MUL, 16'h1234, 16'h0100, 1'b0, 16'h3400, 16'h0012, 5'b00000, 1'b0, 17};
    vt[4]  = '{OP_DIV, 16'h0064, 16'h0007, 1'b0, 16'h000E, 16'h0002, 5'b00000, 1'b0, 17};
    vt[5]  = '{OP_MOD, 16'h0064, 16'h0007, 1'b0, 16'h0002, 16'h0002, 5'b00000, 1'b0, 17};
    vt[6]  = '{OP_DIV, 16'h0064, 16'h0000, 1'b0, 16'hFFFF, 16'h0064, 5'b10010, 1'b0, 2};
    vt[7]  = '{OP_LSL, 16'h8001, 16'h0001, 1'b0, 16'h0002, 16'h0064, 5'b00100, 1'b0, 2};
    vt[8]  = '{OP_LSR, 16'h8001, 16'h0014, 1'b0, 16'h0000, 16'h0064, 5'b00001, 1'b0, 2};
    vt[9]  = '{OP_RSR, 16'h000A, 16'h0003, 1'b0, 16'h4001, 16'h0064, 5'b00000, 1'b0, 2};
    vt[10] = '{5'd0,   16'h0001, 16'h0002, 1'b0, 16'h4001, 16'h0064, 5'b00000, 1'b1, 2};
    vt[11] = '{OP_INC, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 16'h0064, 5'b00101, 1'b0, 2};
    vt[12] = '{OP_DEC, 16'h8000, 16'h0000, 1'b0, 16'h7FFF, 16'h0064, 5'b01000, 1'b0, 2};
    vt[13] = '{OP_AND, 16'hF0F0, 16'hFF00, 1'b0, 16'hF000, 16'h0064, 5'b00010, 1'b0, 2};
    vt[14] = '{OP_XOR, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 16'h0064, 5'b00001, 1'b0, 2};
    vt[15] = '{OP_RSL, 16'h8001, 16'h0014, 1'b0, 16'h0018, 16'h0064, 5'b00000, 1'b0, 2};
    vt[16] = '{OP_SUB, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'h0064, 5'b00110, 1'b0, 2};
    vt[17] = '{OP_ADD, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 16'h0064, 5'b00101, 1'b0, 2};
    vt[18] = '{5'd31,  16'h1111, 16'h2222, 1'b0, 16'h0000, 16'h0064, 5'b00101, 1'b1, 2};
    vt[19] = '{OP_MOV, 16'h1234, 16'h0000, 1'b0, 16'h1234, 16'h0064, 5'b00000, 1'b0, 2};
    vt[20] = '{OP_NOT, 16'h00FF, 16'h0000, 1'b0, 16'hFF00, 16'h0064, 5'b00010, 1'b0, 2};
    vt[21] = '{OP_LSL, 16'h0001, 16'h0010, 1'b0, 16'h0000, 16'h0064, 5'b00101, 1'b0, 2};
    vt[22] = '{OP_OR,  16'h0F00, 16'h00F0, 1'b0, 16'h0FF0, 16'h0064, 5'b00000, 1'b0, 2};
    vt[23] = '{OP_MOD, 16'h0064, 16'h0000, 1'b0, 16'hFFFF, 16'h0064, 5'b10010, 1'b0, 2};
    vt[24] = '{OP_CMP, 16'h0003, 16'h0005, 1'b0, 16'hFFFF, 16'h0064, 5'b00110, 1'b0, 2};
    vt[25] = '{OP_LSR, 16'h8001, 16'h0000, 1'b0, 16'h8001, 16'h0064, 5'b00010, 1'b0, 2};
    vt[26] = '{OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'hFFFE, 5'b00000, 1'b0, 17};
    vt[27] = '{OP_DIV, 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 5'b00010, 1'b0, 17};

    rst       = 1'b1;
    op_valid  = 1'b0;
    op_code   = '0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    op_valid8 = 1'b0;
    op_code8  = '0;
    a8        = '0;
    b8        = '0;
    cin8      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",  {31'h0, op_ready}, 32'h1);
    check("rst_valid",  {31'h0, res_valid}, 32'h0);
    check("rst_result", {16'h0, result}, 32'h0);
    check("rst_aux",    {16'h0, aux}, 32'h0);
    check("rst_flags",  {27'h0, flags}, 32'h0);
    check("rst_err",    {31'h0, err}, 32'h0);
    rst = 1'b0;

    // Each op is presented in the res_valid cycle of the previous one.
    for (int i = 0; i < 28; i++) exec_check($sformatf("v%0d", i), vt[i]);

    // Busy requests are ignored: ADD presented throughout MUL, taken only afterwards.
    run_op(OP_MUL, 16'h0003, 16'h0005, 1'b0, 1'b1, OP_ADD, 16'h0001, 16'h0001, lat, bok);
    check("hold_mul_lat",   32'(lat), 32'd17);
    check("hold_mul_res",   {16'h0, result}, 32'h000F);
    check("hold_mul_aux",   {16'h0, aux}, 32'h0000);
    check("hold_mul_ready", {31'h0, bok}, 32'h1);
    run_op(OP_ADD, 16'h0001, 16'h0001, 1'b0, 1'b0, 5'd0, 16'h0, 16'h0, lat, bok);
    check("hold_add_lat", 32'(lat), 32'd2);
    check("hold_add_res", {16'h0, result}, 32'h0002);

    run_op(OP_DIV, 16'h0055, 16'h0000, 1'b0, 1'b0, 5'd0, 16'h0, 16'h0, lat, bok);
    check("dz_res",   {16'h0, result}, 32'hFFFF);
    check("dz_aux",   {16'h0, aux}, 32'h0055);
    check("dz_flags", {27'h0, flags}, 32'h12);

    // Reset five cycles into a multiply aborts it.
    op_code  = OP_MUL;
    a        = 16'h00FF;
    b        = 16'h0101;
    op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("abort_busy", {31'h0, op_ready}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_ready",  {31'h0, op_ready}, 32'h1);
    check("abort_valid",  {31'h0, res_valid}, 32'h0);
    check("abort_result", {16'h0, result}, 32'h0);
    check("abort_aux",    {16'h0, aux}, 32'h0);
    check("abort_flags",  {27'h0, flags}, 32'h0);
    check("abort_err",    {31'h0, err}, 32'h0);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (res_valid) seen = 1'b1;
    end
    check("abort_no_valid", {31'h0, seen}, 32'h0);

    run_op(OP_MUL, 16'h0003, 16'h0005, 1'b0, 1'b0, 5'd0, 16'h0, 16'h0, lat, bok);
    check("post_abort_lat", 32'(lat), 32'd17);
    check("post_abort_res", {16'h0, result}, 32'h000F);

    // Eight-bit instance: iterative latency scales with WIDTH.
    run8("w8_mul", OP_MUL, 8'h34, 8'h10, 8'h40, 8'h03, 5'b00000, 9);
    run8("w8_div", OP_DIV, 8'hC8, 8'h07, 8'h1C, 8'h04, 5'b00000, 9);
    run8("w8_add", OP_ADD, 8'h7F, 8'h01, 8'h80, 8'h04, 5'b01010, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_seq_core.md
# alu_seq_core

Parametrised, handshaked successor of the 16-bit ALU state machine: one operation is accepted at a time over a valid/ready interface, executed in one cycle (add, logic, shift, rotate) or iteratively (multiply, divide, mod), and returned with a one-cycle result strobe plus status flags. It sits between the instruction decoder and the register-file write-back in the general-purpose processor. It replaces the free-running op_code polling of the previous generation with explicit accept/complete events.

## Interface
- WIDTH, 16, operand/result width; must be at least 4.
- SHW, $clog2(WIDTH), width of the shift/rotate amount field.
- clk  in  1  clock; all state is updated on its rising edge.
- rst  in  1  synchronous reset, active-high.
- op_valid  in  1  request present.
- op_ready  out  1  core can accept; high exactly when the state is IDLE.
- op_code  in  5  operation; encodings unchanged: ADD=1, SUB=2, INC=3, DEC=4, MOD=5, AND=6, CMP=7, MOV=8, NOT=9, OR=10, XOR=11, MUL=12, LSL=13, LSR=14, RSL=15, RSR=16, DIV=17.
- a, b  in  WIDTH  operands.
- cin  in  1  carry-in for ADD / borrow-in for SUB.
- res_valid  out  1  single-cycle completion pulse.
- result  out  WIDTH  primary result; holds its value between operations.
- aux  out  WIDTH  DIV/MOD remainder, MUL upper half; holds otherwise.
- flags  out  5  {DZ,V,C,N,Z}.
- err  out  1  pulses with res_valid for an illegal op_code.

## Operation
- Accept: op_valid && op_ready at a rising edge. op_code, a, b and cin are latched at that edge; inputs are ignored afterwards.
- States:
  - IDLE: goes to EXEC for single-cycle ops, to MUL_IT for MUL, to DIV_IT for DIV/MOD.
  - EXEC: writes result and returns to IDLE.
  - MUL_IT: WIDTH-cycle shift-add.
  - DIV_IT: WIDTH-cycle restoring division; divisor 0 skips iteration.
- Arithmetic, all modulo 2^WIDTH:
  - ADD: a+b+cin.
  - SUB: a-b-cin.
  - INC: a+1.
  - DEC: a-1.
  - MUL: 2·WIDTH-bit unsigned product; low half to result, high half to aux.
  - DIV: unsigned quotient to result, remainder to aux.
  - MOD: remainder to both result and aux.
- Logic ops (AND, OR, XOR, NOT): bitwise. MOV: result=a.
- CMP: computes a-b; updates flags only; result and aux unchanged.
- Shifts:
  - LSL/LSR use the full b; b≥WIDTH gives 0.
  - RSL/RSR rotate by b[SHW-1:0].
- Flags, updated on every completion except illegal op:
  - Z: result==0 (for CMP, difference==0).
  - N: MSB of result/difference.
  - C: carry-out for ADD/INC; borrow for SUB/DEC/CMP; last bit shifted out for LSL/LSR (0 if amount is 0); 0 for all other ops.
  - V: signed overflow for ADD/SUB/CMP/INC/DEC; 0 otherwise.
  - DZ: set only by DIV/MOD with b==0.
- Divide by zero: result=all ones, aux=a, DZ=1; completes in EXEC timing (2 cycles).
- Illegal op_code (0, 18–31): accepted, completes in 2 cycles with err=1; result, aux and flags unchanged.

## Timing
- Reset: state IDLE, op_ready=1, result=0, aux=0, flags=0, res_valid=0, err=0, iteration counter 0.
- Accept at edge E0:
  - Single-cycle ops: res_valid high in the cycle after edge E0+2.
  - MUL, DIV, MOD: res_valid after edge E0+WIDTH+1.
- op_ready rises in the same cycle res_valid is high, so a new op may be accepted there. Peak throughput: one single-cycle op per 2 cycles.
- No backpressure on results: res_valid is a one-cycle pulse.
- op_valid while busy: ignored; the requester must hold it until op_ready.
- rst during MUL_IT/DIV_IT: aborts immediately, no res_valid, all outputs return to reset values.

## Structure
- Package alu_seq_pkg:
  - op_code localparams;
  - state enum (IDLE, EXEC, MUL_IT, DIV_IT);
  - flag bit indices (Z=0, N=1, C=2, V=3, DZ=4).
- Sub-module alu_seq_iter: shared WIDTH-parameterised iterative datapath.
  - Contains the partial-product/remainder register, quotient/multiplier register and down-counter.
  - Inputs: start, mode (mul/div).
  - Outputs: done, hi, lo.
- Everything else (single-cycle datapath, FSM, flag logic) lives in alu_seq_core.

## Test plan
- WIDTH=16, ADD a=0x7FFF b=1 cin=0 → result 0x8000, flags N=1 V=1 C=0 Z=0, res_valid 2 cycles after accept.
- SUB a=5 b=7 then CMP a=9 b=9 back-to-back (second accepted in the res_valid cycle) → result 0xFFFE with C=1; then Z=1, result still 0xFFFE.
- MUL a=0x1234 b=0x0100 → result 0x3400, aux 0x0012, res_valid exactly 17 cycles after accept, op_ready low throughout.
- DIV a=100 b=7 → result 14, aux 2; MOD same → result 2; DIV b=0 → result 0xFFFF, aux 100, DZ=1 in 2 cycles.
- LSL a=0x8001 b=1 → 0x0002 with C=1; LSR b=20 → 0; RSR a=10 b=3 → 0x4001; op_code 0 → err pulse, result unchanged.
- rst asserted 5 cycles into MUL → no res_valid, all outputs zero next cycle, op_ready=1; WIDTH=8 rerun of the MUL test gives 9-cycle latency.
